cd_rs_parity_encoder: RTL and testbench



---
 rtl/cd_rs_parity_encoder.sv | 182 ++++++++++++++++++
 tb/tb_cd_rs_parity_encoder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cd_rs_parity_encoder.sv
// Streaming systematic RS(K+4,K) encoder over GF(2^8) for CD CIRC C1/C2.
// Define CD_PARITY_INVERT_EN to emit parity bytes bitwise inverted.
module cd_rs_parity_encoder #(
   parameter int K = 28
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_parity,
   output logic       out_last
);

   localparam logic [1:0] ST_DATA   = 2'd0;
   localparam logic [1:0] ST_PARITY = 2'd1;
   localparam logic [1:0] ST_DRAIN  = 2'd2;

   localparam logic [7:0] K_LAST = 8'(K - 1);

`ifdef CD_PARITY_INVERT_EN
   localparam logic [7:0] PAR_MASK = 8'hFF;
`else
   localparam logic [7:0] PAR_MASK = 8'h00;
`endif

   // Shift-and-add multiply mod 0x11D; constant b folds to XOR trees.
   function automatic logic [7:0] gf_mul(
      input logic [7:0] a,
      input logic [7:0] b
   );
      logic [7:0] acc;
      logic [7:0] x;
      acc = 8'h00;
      x   = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
      end
      return acc;
   endfunction

   logic [1:0] state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [1:0] pcnt_q, pcnt_d;
   logic [7:0] r3_q, r3_d;
   logic [7:0] r2_q, r2_d;
   logic [7:0] r1_q, r1_d;
   logic [7:0] r0_q, r0_d;
   logic [7:0] od_q, od_d;
   logic       ov_q, ov_d;
   logic       op_q, op_d;
   logic       ol_q, ol_d;

   logic       out_free;
   logic       rdy;
   logic       accept;
   logic [7:0] fb;
   logic [7:0] par_sel;

   assign out_free = !ov_q || out_ready;
   assign rdy      = !rst && out_free &&
                     (state_q == ST_DATA || state_q == ST_DRAIN);
   assign accept   = in_valid && rdy;
   assign fb       = in_data ^ r3_q;

   always_comb begin
      par_sel = r0_q;
      unique case (pcnt_q)
         2'd0:    par_sel = r3_q;
         2'd1:    par_sel = r2_q;
         2'd2:    par_sel = r1_q;
         default: par_sel = r0_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pcnt_d  = pcnt_q;
      r3_d    = r3_q;
      r2_d    = r2_q;
      r1_d    = r1_q;
      r0_d    = r0_q;
      od_d    = od_q;
      ov_d    = ov_q;
      op_d    = op_q;
      ol_d    = ol_q;
      if (accept) begin
         r3_d = r2_q ^ gf_mul(fb, 8'h0F);
         r2_d = r1_q ^ gf_mul(fb, 8'h36);
         r1_d = r0_q ^ gf_mul(fb, 8'h78);
         r0_d = gf_mul(fb, 8'h40);
         od_d = in_data;
         ov_d = 1'b1;
         op_d = 1'b0;
         ol_d = 1'b0;
         if (cnt_q == K_LAST) begin
            cnt_d   = 8'd0;
            state_d = ST_PARITY;
         end else begin
            cnt_d   = cnt_q + 8'd1;
            state_d = ST_DATA;
         end
      end else begin
         case (state_q)
            ST_DATA: begin
               if (out_free) begin
                  ov_d = 1'b0;
                  op_d = 1'b0;
                  ol_d = 1'b0;
               end
            end
            ST_PARITY: begin
               if (out_free) begin
                  od_d   = par_sel ^ PAR_MASK;
                  ov_d   = 1'b1;
                  op_d   = 1'b1;
                  ol_d   = (pcnt_q == 2'd3);
                  pcnt_d = pcnt_q + 2'd1;
                  if (pcnt_q == 2'd3) begin
                     r3_d    = 8'h00;
                     r2_d    = 8'h00;
                     r1_d    = 8'h00;
                     r0_d    = 8'h00;
                     pcnt_d  = 2'd0;
                     state_d = ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               // Last parity leaves with no new byte behind it.
               if (out_ready) begin
                  ov_d    = 1'b0;
                  op_d    = 1'b0;
                  ol_d    = 1'b0;
                  state_d = ST_DATA;
               end
            end
            default: state_d = ST_DATA;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_DATA;
         cnt_q   <= 8'd0;
         pcnt_q  <= 2'd0;
         r3_q    <= 8'h00;
         r2_q    <= 8'h00;
         r1_q    <= 8'h00;
         r0_q    <= 8'h00;
         od_q    <= 8'h00;
         ov_q    <= 1'b0;
         op_q    <= 1'b0;
         ol_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pcnt_q  <= pcnt_d;
         r3_q    <= r3_d;
         r2_q    <= r2_d;
         r1_q    <= r1_d;
         r0_q    <= r0_d;
         od_q    <= od_d;
         ov_q    <= ov_d;
         op_q    <= op_d;
         ol_q    <= ol_d;
      end
   end

   assign in_ready   = rdy;
   assign out_data   = rst ? 8'h00 : od_q;
   assign out_valid  = ov_q && !rst;
   assign out_parity = op_q && !rst;
   assign out_last   = ol_q && !rst;

endmodule

// File: tb/tb_cd_rs_parity_encoder.sv
// Directed bench for cd_rs_parity_encoder (K=28 and K=24 instances).
// Parity is checked by codeword syndromes at alpha^0..alpha^3.
module tb_cd_rs_parity_encoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b1;
   logic       sel = 1'b0;

   logic       a_ir, a_ov, a_op, a_ol;
   logic [7:0] a_od;
   logic       b_ir, b_ov, b_op, b_ol;
   logic [7:0] b_od;
   logic       ir, ov, op, ol;
   logic [7:0] od;

   always #5 clk = ~clk;

   cd_rs_parity_encoder #(.K(28)) u_a (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid && !sel),
      .in_ready(a_ir),
      .out_data(a_od), .out_valid(a_ov),
      .out_ready(out_ready),
      .out_parity(a_op), .out_last(a_ol)
   );

   cd_rs_parity_encoder #(.K(24)) u_b (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid && sel),
      .in_ready(b_ir),
      .out_data(b_od), .out_valid(b_ov),
      .out_ready(out_ready),
      .out_parity(b_op), .out_last(b_ol)
   );

   assign ir = sel ? b_ir : a_ir;
   assign ov = sel ? b_ov : a_ov;
   assign op = sel ? b_op : a_op;
   assign ol = sel ? b_ol : a_ol;
   assign od = sel ? b_od : a_od;

`ifdef CD_PARITY_INVERT_EN
   localparam logic [7:0] INV = 8'hFF;
`else
   localparam logic [7:0] INV = 8'h00;
`endif

   int n_run  = 0;
   int n_fail = 0;
   int ncyc;
   int nlow;

   logic [7:0] msgs[$];
   logic [9:0] outs[$];
   logic [9:0] ref_outs[$];

   task automatic check(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(
      input logic [7:0] a,
      input logic [7:0] b
   );
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
      end
      return p;
   endfunction

   task automatic run_stream(input int nexp, input bit thr);
      int         idx;
      logic       stall;
      logic [9:0] held;
      idx   = 0;
      stall = 1'b0;
      held  = 10'h0;
      ncyc  = 0;
      nlow  = 0;
      outs.delete();
      while (outs.size() < nexp && ncyc < 20000) begin
         @(negedge clk);
         in_valid  = (idx < msgs.size()) &&
                     (!thr || $urandom_range(0, 1) == 1);
         in_data   = in_valid ? msgs[idx] : 8'h5A;
         out_ready = !thr || $urandom_range(0, 1) == 1;
         #1;
         ncyc++;
         if (!ir) nlow++;
         if (stall)
            check("stall_hold", {21'h0, ov, ol, op, od}, {21'h0, 1'b1, held});
         if (in_valid && ir) idx++;
         if (ov && out_ready) outs.push_back({ol, op, od});
         stall = ov && !out_ready;
         held  = {ol, op, od};
      end
      in_valid = 1'b0;
      check("stream_len", outs.size(), nexp);
   endtask

   task automatic check_blocks(input int k);
      int         nb;
      logic [7:0] s[4];
      logic [7:0] c;
      logic [9:0] o;
      nb = msgs.size() / k;
      if (outs.size() != nb * (k + 4)) return;
      for (int b = 0; b < nb; b++) begin
         for (int j = 0; j < 4; j++) s[j] = 8'h00;
         for (int i = 0; i < k + 4; i++) begin
            o = outs[b * (k + 4) + i];
            if (i < k) begin
               check("msg_byte", o, {2'b00, msgs[b * k + i]});
               c = o[7:0];
            end else begin
               check("par_flags", o[9:8], (i == k + 3) ? 2'b11 : 2'b01);
               c = o[7:0] ^ INV;
            end
            for (int j = 0; j < 4; j++)
               s[j] = gmul(s[j], 8'(1 << j)) ^ c;
         end
         check("syndrome", {s[0], s[1], s[2], s[3]}, 32'h0);
      end
   endtask

   function automatic logic [31:0] par_word(input int base);
      if (outs.size() < base + 4) return 32'hDEADBEEF;
      return {outs[base][7:0], outs[base + 1][7:0],
              outs[base + 2][7:0], outs[base + 3][7:0]};
   endfunction

   task automatic load_unit(input int k);
      msgs.delete();
      for (int i = 0; i < k - 1; i++) msgs.push_back(8'h00);
      msgs.push_back(8'h01);
   endtask

   task automatic load_rand(input int n);
      msgs.delete();
      for (int i = 0; i < n; i++) msgs.push_back(8'($urandom_range(0, 255)));
   endtask

   initial begin
      repeat (3) @(negedge clk);
      #1;
      check("rst_outs", {ir, ov, op, ol, od}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("ready_after_rst", {ir, ov}, 2'b10);

      // all-zero block
      msgs.delete();
      for (int i = 0; i < 28; i++) msgs.push_back(8'h00);
      run_stream(32, 1'b0);
      check("zero_cycles", ncyc, 33);
      check("zero_ir_low", nlow, 4);
      check("zero_parity", par_word(28), {4{INV}});
      check_blocks(28);

      // single 0x01 in the last message slot
      load_unit(28);
      run_stream(32, 1'b0);
      check("unit_parity", par_word(28), 32'h0F367840 ^ {4{INV}});
      check_blocks(28);

      // back-to-back random blocks
      load_rand(4 * 28);
      run_stream(4 * 32, 1'b0);
      check("b2b_cycles", ncyc, 4 * 32 + 1);
      check("b2b_ir_low", nlow, 16);
      check_blocks(28);
      ref_outs = outs;

      // same stream under random throttling
      run_stream(4 * 32, 1'b1);
      check_blocks(28);
      check("thr_len", outs.size(), ref_outs.size());
      if (outs.size() == ref_outs.size())
         for (int i = 0; i < outs.size(); i++)
            check("thr_equal", outs[i], ref_outs[i]);

      // K=24 instance
      sel = 1'b1;
      load_unit(24);
      run_stream(28, 1'b0);
      check("k24_unit_parity", par_word(24), 32'h0F367840 ^ {4{INV}});
      check_blocks(24);
      load_rand(3 * 24);
      run_stream(3 * 28, 1'b1);
      check_blocks(24);
      @(negedge clk);
      sel = 1'b0;

      // reset after 10 message bytes
      load_rand(10);
      run_stream(9, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      check("rst_mid_outs", {ir, ov, op, ol, od}, 32'h0);
      @(negedge clk);
      #1;
      check("rst_mid_outs2", {ir, ov, op, ol, od}, 32'h0);
      rst = 1'b0;
      #1;
      check("rst_mid_release", {ir, ov, op, ol}, 4'b1000);
      msgs.delete();
      for (int i = 0; i < 28; i++) msgs.push_back(8'h00);
      run_stream(32, 1'b0);
      check("rst_mid_parity", par_word(28), {4{INV}});
      check_blocks(28);

      // reset after two parity bytes
      load_rand(28);
      run_stream(30, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b0;
      #1;
      check("rst_par_gated", ov, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_par_regs", {ir, ov, op, ol}, 4'b1000);
      load_unit(28);
      run_stream(32, 1'b0);
      check("rst_par_unit", par_word(28), 32'h0F367840 ^ {4{INV}});
      check_blocks(28);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
